// File: rtl/pkg_input_cond.sv
// ----------------------------------------------------------------------------
// pkg_input_cond
//
// Shared definitions for the push-button input-conditioning blocks.
//   - deb_state_t : 2-bit debounce FSM state encoding
//   - DEF_*       : default parameter values for the conditioning stages
//   - is_wait()   : true for the two "change pending" states
// ----------------------------------------------------------------------------
package pkg_input_cond;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } deb_state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_CNT_W           = 5;
    localparam int DEF_CLK_DIV         = 4;
    localparam int DEF_DIV_W           = 3;

    // A level change is being qualified whenever the FSM sits in a WAIT state.
    function automatic logic is_wait(input deb_state_t st);
        return (st == WAIT_HIGH) || (st == WAIT_LOW);
    endfunction

endpackage : pkg_input_cond

// File: rtl/button_debouncer_sync_chain.sv
// ----------------------------------------------------------------------------
// sync_chain
//
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
// Also intended for the preset/clear switch inputs.
//
// Parameters:
//   STAGES   : number of flops in the chain (2..4)
// Ports:
//   clk      : in  system clock
//   rst      : in  asynchronous, active-high reset (chain clears to 0)
//   async_in : in  asynchronous input level
//   sync_out : out synchronized level (last flop of the chain)
// ----------------------------------------------------------------------------
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] sync_reg;

    // Bit 0 is the metastability-exposed capture flop; the value walks toward
    // the MSB one flop per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_reg[STAGES-1];

endmodule : sync_chain

// File: rtl/button_debouncer.sv
// ----------------------------------------------------------------------------
// button_debouncer
//
// Conditions a raw, bouncing push-button into a clean synchronous level for
// the downstream D flip-flop, plus one-cycle rise/fall pulses, and generates
// a divided slow clock that clocks that flip-flop.
//
// Parameters:
//   SYNC_STAGES     : synchronizer depth (2..4)
//   DEBOUNCE_CYCLES : consecutive stable samples needed to commit (>= 1)
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//   CLK_DIV         : fast cycles per slow-clock half period (>= 1)
//   DIV_W           : divider counter width, 2**DIV_W >= CLK_DIV
// Ports:
//   input_clock1_clk_1    : in  system clock (rising edge)
//   input_reset1_rst_2    : in  asynchronous, active-high reset
//   input_push_button_raw : in  raw button, asynchronous to the clock
//   output_d_level        : out debounced level (flip-flop D input)
//   output_d_rise         : out one-cycle pulse on committed 0->1
//   output_d_fall         : out one-cycle pulse on committed 1->0
//   output_slow_clk       : out divided clock, period 2*CLK_DIV, 50% duty
//   output_slow_clk_rise  : out one-cycle pulse as slow_clk goes 0->1
//   output_busy           : out high while a level change is being qualified
// ----------------------------------------------------------------------------
module button_debouncer
    import pkg_input_cond::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int CLK_DIV         = DEF_CLK_DIV,
    parameter int DIV_W           = DEF_DIV_W
) (
    input  logic input_clock1_clk_1,
    input  logic input_reset1_rst_2,
    input  logic input_push_button_raw,
    output logic output_d_level,
    output logic output_d_rise,
    output logic output_d_fall,
    output logic output_slow_clk,
    output logic output_slow_clk_rise,
    output logic output_busy
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    // With a single required sample the IDLE state commits directly.
    localparam bit               COMMIT_IMMEDIATE = (DEBOUNCE_CYCLES == 1);

    logic clk;
    logic rst;
    assign clk = input_clock1_clk_1;
    assign rst = input_reset1_rst_2;

    // ------------------------------------------------------------------
    // Synchronizer: s is the only view of the button the FSM ever uses.
    // ------------------------------------------------------------------
    logic s;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk      (clk),
        .rst      (rst),
        .async_in (input_push_button_raw),
        .sync_out (s)
    );

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    deb_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic             level_reg, level_next;
    logic             rise_reg,  rise_next;
    logic             fall_reg,  fall_next;
    logic             busy_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE_LOW;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
            // Registered from the next state so busy lines up with the
            // cycles the FSM actually spends in a WAIT state.
            busy_reg  <= is_wait(state_next);
        end
    end

    // The IDLE sample that leaves IDLE counts as stable sample #1, so the
    // WAIT state commits when cnt reaches DEBOUNCE_CYCLES-1; cnt can never
    // run past that value and therefore never wraps.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        level_next = level_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;

        case (state_reg)
            IDLE_LOW: begin
                if (s) begin
                    if (COMMIT_IMMEDIATE) begin
                        state_next = IDLE_HIGH;
                        level_next = 1'b1;
                        rise_next  = 1'b1;
                    end else begin
                        state_next = WAIT_HIGH;
                        cnt_next   = CNT_ONE;
                    end
                end
            end

            WAIT_HIGH: begin
                if (!s) begin
                    // Bounce: drop the pending rise silently.
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                    level_next = 1'b1;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next   = cnt_reg + CNT_ONE;
                end
            end

            IDLE_HIGH: begin
                if (!s) begin
                    if (COMMIT_IMMEDIATE) begin
                        state_next = IDLE_LOW;
                        level_next = 1'b0;
                        fall_next  = 1'b1;
                    end else begin
                        state_next = WAIT_LOW;
                        cnt_next   = CNT_ONE;
                    end
                end
            end

            WAIT_LOW: begin
                if (s) begin
                    // Bounce: drop the pending fall silently.
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                    level_next = 1'b0;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next   = cnt_reg + CNT_ONE;
                end
            end

            default: begin
                state_next = IDLE_LOW;
                cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Slow-clock divider, free running and independent of the FSM.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] divcnt_reg,    divcnt_next;
    logic             slow_reg,      slow_next;
    logic             slow_rise_reg, slow_rise_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divcnt_reg    <= '0;
            slow_reg      <= 1'b0;
            slow_rise_reg <= 1'b0;
        end else begin
            divcnt_reg    <= divcnt_next;
            slow_reg      <= slow_next;
            slow_rise_reg <= slow_rise_next;
        end
    end

    always_comb begin
        divcnt_next    = divcnt_reg + DIV_ONE;
        slow_next      = slow_reg;
        slow_rise_next = 1'b0;
        if (divcnt_reg == DIV_LAST) begin
            divcnt_next    = '0;
            slow_next      = ~slow_reg;
            // Pulse in the same cycle slow_clk becomes 1.
            slow_rise_next = ~slow_reg;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all come straight from flops, so every output is 0 as soon
    // as reset asserts and none of them can glitch.
    // ------------------------------------------------------------------
    assign output_d_level       = level_reg;
    assign output_d_rise        = rise_reg;
    assign output_d_fall        = fall_reg;
    assign output_slow_clk      = slow_reg;
    assign output_slow_clk_rise = slow_rise_reg;
    assign output_busy          = busy_reg;

endmodule : button_debouncer

// File: tb/tb_button_debouncer.sv
// ----------------------------------------------------------------------------
// tb_button_debouncer
//
// Self-checking bench for button_debouncer with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, CLK_DIV=3. Expected d_rise/d_fall pulses (kind and the
// edge they must follow) are queued as stimulus is applied and matched by a
// monitor when the DUT emits them; levels, busy and the divider are checked
// directly against values derived from the timing rules.
// ----------------------------------------------------------------------------
module tb_button_debouncer;

    localparam int KIND_RISE = 1;
    localparam int KIND_FALL = 2;

    logic clk;
    logic rst;
    logic raw;
    logic d_level;
    logic d_rise;
    logic d_fall;
    logic slow_clk;
    logic slow_clk_rise;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;   // number of rising edges seen so far
    int base     = 0;   // edge number of "edge 0" of the current scenario

    typedef struct {
        int kind;
        int cyc;
    } pulse_t;

    pulse_t exp_q[$];

    button_debouncer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3),
        .CLK_DIV         (3),
        .DIV_W           (2)
    ) dut (
        .input_clock1_clk_1    (clk),
        .input_reset1_rst_2    (rst),
        .input_push_button_raw (raw),
        .output_d_level        (d_level),
        .output_d_rise         (d_rise),
        .output_d_fall         (d_fall),
        .output_slow_clk       (slow_clk),
        .output_slow_clk_rise  (slow_clk_rise),
        .output_busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until just after edge k of the current scenario.
    task automatic to_edge(input int k);
        while (cyc < base + k) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},     d_level,       0);
        check({tag, "_rise"},      d_rise,        0);
        check({tag, "_fall"},      d_fall,        0);
        check({tag, "_slow"},      slow_clk,      0);
        check({tag, "_slow_rise"}, slow_clk_rise, 0);
        check({tag, "_busy"},      busy,          0);
    endtask

    // Pulse monitor: every d_rise/d_fall must match the head of the queue.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (d_rise === 1'b1 && d_fall === 1'b1)
                check("rise_fall_exclusive", 1, 0);
            if (d_rise === 1'b1 || d_fall === 1'b1) begin
                int     kind;
                pulse_t e;
                kind = (d_rise === 1'b1) ? KIND_RISE : KIND_FALL;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse_kind", kind, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("pulse %s at edge %0d (expected kind %0d at edge %0d)",
                             (kind == KIND_RISE) ? "rise" : "fall", cyc, e.kind, e.cyc);
                    check("pulse_kind", kind, e.kind);
                    check("pulse_edge", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rises;
        rst = 1'b0;
        raw = 1'b0;

        // ---- Reset before any clock edge: outputs must clear at once ----
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset");
        step();
        step();
        rst = 1'b0;
        base = cyc;

        // ---- Idle with raw=0, divider free running for 24 cycles ----
        rises = 0;
        for (int k = 1; k <= 24; k++) begin
            step();
            check("div_slow", slow_clk, (k / 3) % 2);
            check("div_slow_rise", slow_clk_rise, ((k % 3) == 0 && ((k / 3) % 2) == 1) ? 1 : 0);
            if (slow_clk_rise === 1'b1) rises++;
            if (k <= 10) begin
                check("idle_level", d_level, 0);
                check("idle_busy", busy, 0);
            end
        end
        check("div_rise_count", rises, 4);
        $display("divider: %0d slow_clk rises in 24 cycles", rises);

        // ---- Bounce rejection: raw 1,1,0,1,1 then 0 ----
        raw = 1'b1;
        base = cyc + 1;
        to_edge(1); raw = 1'b0;
        to_edge(2); check("bounce_busy_e2", busy, 1); raw = 1'b1;
        to_edge(4); check("bounce_busy_e4", busy, 0); raw = 1'b0;
        to_edge(5); check("bounce_busy_e5", busy, 1);
        to_edge(7); check("bounce_busy_e7", busy, 0);
        to_edge(12);
        check("bounce_level", d_level, 0);
        check("bounce_busy_end", busy, 0);
        check("bounce_pending", exp_q.size(), 0);
        $display("bounce rejection done at edge %0d", cyc);

        // ---- Clean press: d_level after edge 5 ----
        raw = 1'b1;
        base = cyc + 1;
        exp_q.push_back('{KIND_RISE, base + 5});
        to_edge(1); check("press_busy_e1", busy, 0);
        to_edge(2); check("press_busy_e2", busy, 1);
        to_edge(4);
        check("press_level_e4", d_level, 0);
        check("press_busy_e4", busy, 1);
        to_edge(5);
        check("press_level_e5", d_level, 1);
        check("press_rise_e5", d_rise, 1);
        check("press_busy_e5", busy, 0);
        to_edge(6);
        check("press_rise_e6", d_rise, 0);
        check("press_level_e6", d_level, 1);
        to_edge(10);
        check("press_pending", exp_q.size(), 0);

        // ---- Release with a one-cycle glitch: fall after edge 8 ----
        raw = 1'b0;
        base = cyc + 1;
        exp_q.push_back('{KIND_FALL, base + 8});
        to_edge(1); raw = 1'b1;
        to_edge(2); check("release_busy_e2", busy, 1); raw = 1'b0;
        to_edge(4);
        check("release_busy_e4", busy, 0);
        check("release_level_e4", d_level, 1);
        to_edge(5); check("release_busy_e5", busy, 1);
        to_edge(7);
        check("release_level_e7", d_level, 1);
        check("release_busy_e7", busy, 1);
        to_edge(8);
        check("release_level_e8", d_level, 0);
        check("release_fall_e8", d_fall, 1);
        check("release_busy_e8", busy, 0);
        to_edge(9); check("release_fall_e9", d_fall, 0);
        to_edge(14);
        check("release_pending", exp_q.size(), 0);

        // ---- Reset while in WAIT_HIGH, then full latency restarts ----
        raw = 1'b1;
        base = cyc + 1;
        to_edge(3); check("wreset_busy_e3", busy, 1);
        rst = 1'b1;
        #1 check_all_zero("wreset");
        step();
        check("wreset_level_hold", d_level, 0);
        rst = 1'b0;
        base = cyc + 1;
        exp_q.push_back('{KIND_RISE, base + 5});
        to_edge(4); check("wreset_level_e4", d_level, 0);
        to_edge(5);
        check("wreset_level_e5", d_level, 1);
        check("wreset_rise_e5", d_rise, 1);
        to_edge(6); check("wreset_rise_e6", d_rise, 0);
        to_edge(10);
        check("wreset_pending", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_button_debouncer

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Input-conditioning stage directly upstream of the D flip-flop block. It turns a raw, asynchronous, bouncing push-button into a clean synchronous level that drives the flip-flop D input.
- Also provides single-cycle rise/fall pulses and a divided slow clock that drives the flip-flop clock, so board-level stimulus is glitch-free and human-observable.

Parameters:
- SYNC_STAGES, 2: synchronizer flop count; legal range 2..4.
- DEBOUNCE_CYCLES, 16: consecutive stable synced samples required to commit a level change; minimum 1.
- CNT_W, 5: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- CLK_DIV, 4: fast cycles per slow-clock half-period; minimum 1.
- DIV_W, 3: divider counter width; must satisfy 2^DIV_W >= CLK_DIV.

Ports:
- input_clock1_clk_1  in  1  system clock; all state updates on its rising edge.
- input_reset1_rst_2  in  1  reset, asynchronous assert, active-high.
- input_push_button_raw  in  1  raw button, asynchronous to the clock.
- output_d_level  out  1  debounced level; feeds the flip-flop D input.
- output_d_rise  out  1  one-cycle pulse on a committed 0->1 change.
- output_d_fall  out  1  one-cycle pulse on a committed 1->0 change.
- output_slow_clk  out  1  divided clock; feeds the flip-flop clock.
- output_slow_clk_rise  out  1  one-cycle pulse coincident with output_slow_clk going 0->1.
- output_busy  out  1  high while the FSM is in WAIT_HIGH or WAIT_LOW.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - While reset is high: synchronizer flops = 0, state = IDLE_LOW, debounce counter = 0, divider counter = 0.
  - While reset is high: every output = 0.
  - Release is sampled on the first rising edge after deassertion.
  - Reset mid-debounce discards the pending change; no pulse is emitted.
- Synchronizer: SYNC_STAGES-flop chain. Its output s is the only signal the FSM reads.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
- IDLE_LOW:
  - s=1 and DEBOUNCE_CYCLES=1 -> IDLE_HIGH, d_level<=1, d_rise<=1.
  - s=1 otherwise -> WAIT_HIGH, cnt<=1.
- WAIT_HIGH:
  - s=0 -> IDLE_LOW, cnt<=0, no pulse (bounce rejected).
  - cnt=DEBOUNCE_CYCLES-1 with s=1 -> IDLE_HIGH, cnt<=0, d_level<=1, d_rise<=1.
  - Otherwise cnt<=cnt+1.
- IDLE_HIGH / WAIT_LOW: mirror images of the above, using d_fall and d_level<=0.
- Pulses: d_rise and d_fall are registered and high for exactly one cycle. They are never high together.
- Latency: raw held stable from edge 0 -> d_level changes after edge SYNC_STAGES+DEBOUNCE_CYCLES-1.
- Counter: never wraps; saturation is prevented by the transition at DEBOUNCE_CYCLES-1.
- busy: registered, derived from the next state.
- Divider:
  - divcnt counts 0..CLK_DIV-1; at CLK_DIV-1 it wraps to 0 and toggles slow_clk.
  - Slow-clock period = 2*CLK_DIV fast cycles, 50% duty.
  - slow_clk_rise=1 in the cycle slow_clk becomes 1.
  - Divider runs independently of the debounce FSM.
- d_level is registered and changes only on a fast-clock edge. Consumers clocked by slow_clk see a level that is stable for at least one fast cycle around the slow edge.

Decomposition:
- Shared package pkg_input_cond:
  - 2-bit state typedef: IDLE_LOW=0, WAIT_HIGH=1, IDLE_HIGH=2, WAIT_LOW=3.
  - Default constants for SYNC_STAGES, DEBOUNCE_CYCLES, CLK_DIV.
- Sub-module sync_chain (parameter STAGES; ports clock, reset, async in, sync out). Reused later for the preset/clear switches.
- Debounce FSM, counter and divider stay in button_debouncer.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CLK_DIV=3):
- Reset: assert reset mid-cycle, no clock edge -> all outputs 0 immediately. Release; hold raw=0 for 10 cycles -> outputs stay 0, busy=0.
- Clean press: raw 0->1 before edge 0 and held -> d_level=1 after edge 5, d_rise=1 for exactly cycle 5->6, busy=1 during cycles 3-5.
- Bounce rejection: raw high 2 cycles, low 1, high 2, then low -> d_level stays 0, no d_rise, FSM returns to IDLE_LOW.
- Release with bounce, starting from d_level=1: raw 1->0, glitch 1 for one cycle at cycle 2, then low -> d_fall fires once, 4 stable samples after the glitch clears. Never a spurious d_rise.
- Reset in WAIT_HIGH: assert reset at cycle 4 of a press -> d_level=0, no pulse. After release with raw still 1 -> full 5-edge latency restarts.
- Divider: 24 free-running cycles after reset -> slow_clk toggles every 3 cycles (period 6), 4 slow_clk_rise pulses, each 1 cycle wide.
